// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: write-master state encoding and BRESP/RRESP codes.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        WM_IDLE   = 2'd0,
        WM_SEND   = 2'd1,
        WM_WAIT_B = 2'd2
    } wr_master_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_watchdog.sv
// Saturating transaction watchdog; expired_c_o flags the last allowed cycle (LIMIT=0 disables it).
module axi4_lite_watchdog #(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c_o
);
    localparam int unsigned CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != CNT_W'(LIMIT))) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expired_c_o = (LIMIT != 0) && en_i && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/axi4_lite_write_master.sv
// Single-outstanding AXI4-Lite write engine: captures a store, issues AW/W independently,
// waits for B and returns a one-cycle completion, optionally bounded by a watchdog.
module axi4_lite_write_master
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    output logic                      resp_valid,
    output logic                      resp_err,
    output logic                      resp_timeout,
    output logic                      busy,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    wr_master_state_e        state_q, state_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [STRB_WIDTH-1:0]   strb_q, strb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    resp_err_q, resp_err_d;
    logic                    resp_to_q, resp_to_d;
    logic                    req_ready_q, req_ready_d;
    logic                    busy_q, busy_d;

    logic aw_hs_c, w_hs_c, b_hs_c;
    logic wd_clr_c, wd_expired_c;

    assign aw_hs_c = awvalid_q && M_AXI_AWREADY;
    assign w_hs_c  = wvalid_q && M_AXI_WREADY;
    assign b_hs_c  = bready_q && M_AXI_BVALID;

    axi4_lite_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (wd_clr_c),
        .en_i        (state_q != WM_IDLE),
        .expired_c_o (wd_expired_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= WM_IDLE;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            strb_q       <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_to_q    <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            strb_q       <= strb_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_to_q    <= resp_to_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
        end
    end

    // Channel valids are computed for the next cycle so every output leaves a flop.
    always_comb begin
        state_d      = state_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        addr_d       = addr_q;
        data_d       = data_q;
        strb_d       = strb_q;
        awvalid_d    = 1'b0;
        wvalid_d     = 1'b0;
        bready_d     = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_to_d    = 1'b0;
        wd_clr_c     = 1'b0;

        unique case (state_q)
            WM_IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    data_d    = req_wdata;
                    strb_d    = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    wd_clr_c  = 1'b1;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = WM_SEND;
                end
            end
            WM_SEND: begin
                aw_done_d = aw_done_q || aw_hs_c;
                w_done_d  = w_done_q || w_hs_c;
                if (wd_expired_c) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_to_d    = 1'b1;
                    state_d      = WM_IDLE;
                end else if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = WM_WAIT_B;
                end else begin
                    awvalid_d = !aw_done_d;
                    wvalid_d  = !w_done_d;
                end
            end
            WM_WAIT_B: begin
                // A B handshake on the expiry cycle still counts as a normal response.
                if (b_hs_c) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = (M_AXI_BRESP != RESP_OKAY);
                    state_d      = WM_IDLE;
                end else if (wd_expired_c) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_to_d    = 1'b1;
                    state_d      = WM_IDLE;
                end else begin
                    bready_d = 1'b1;
                end
            end
            default: begin
                state_d = WM_IDLE;
            end
        endcase

        req_ready_d = (state_d == WM_IDLE);
        busy_d      = (state_d != WM_IDLE);
    end

    assign req_ready     = req_ready_q;
    assign busy          = busy_q;
    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign resp_timeout  = resp_to_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = data_q;
    assign M_AXI_WSTRB   = strb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;

endmodule
